// File: rtl/fetch_queue.sv
// fetch_queue: prefetching instruction-fetch stage.
//
// Keeps up to DEPTH in-order requests in flight to instruction memory and
// buffers the returned words together with their PCs in a circular queue.
// Decode drains the queue through a valid/ready handshake. A redirect
// flushes the queue, restarts fetch at a new PC and drops every response
// that is still in flight for the old stream.
//
// Parameters:
//   XLEN     - data/address width
//   DEPTH    - queue entries plus outstanding requests (power of two, >= 2)
//   RESET_PC - first fetch address after reset
//
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   imem_req_o      - fetch request valid
//   imem_addr_o     - fetch address (word aligned)
//   imem_gnt_i      - request accepted this cycle
//   imem_rvalid_i   - response valid (in request order)
//   imem_rdata_i    - returned instruction word
//   redirect_i      - flush and restart fetch
//   redirect_pc_i   - restart address
//   id_valid_o      - instruction available to decode
//   id_ready_i      - decode accepts the head instruction
//   id_instr_o      - head instruction
//   id_pc_o         - PC of id_instr_o
//   empty_o         - queue holds no entries
//
// Build option:
//   FETCH_BYPASS_EN - when defined, a response arriving while the queue is
//                     empty is forwarded to decode in the same cycle. When
//                     undefined, every word goes through the queue and there
//                     is no combinational path from imem_* to id_*.

module fetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [31:0]     imem_rdata_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            id_valid_o,
  input  logic            id_ready_i,
  output logic [31:0]     id_instr_o,
  output logic [XLEN-1:0] id_pc_o,
  output logic            empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  // In-flight and discard counters get one extra bit: right after a
  // redirect the old stream's responses and a full new credit window can
  // both be outstanding at once.
  localparam int OUT_W = CNT_W + 1;
  localparam logic [OUT_W:0] DEPTH_V = (OUT_W + 1)'(DEPTH);

  logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]  resp_pc_q,  resp_pc_d;
  logic [PTR_W-1:0] rd_ptr_q,   rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q,   wr_ptr_d;
  logic [CNT_W-1:0] count_q,    count_d;
  logic [OUT_W-1:0] outst_q,    outst_d;
  logic [OUT_W-1:0] discard_q,  discard_d;

  logic [XLEN-1:0]  pc_mem    [DEPTH];
  logic [31:0]      instr_mem [DEPTH];

  logic [OUT_W:0]   credit_used;
  logic             grant;
  logic             drop;
  logic             accept;
  logic             bypass_hit;
  logic             push;
  logic             pop;
  logic             queue_nonempty;

  // Slots already promised: buffered entries plus responses still to come
  // that will actually be kept. Issuing only below DEPTH guarantees every
  // kept response finds a free queue slot.
  assign credit_used = {1'b0, count_q} + {1'b0, outst_q} - {1'b0, discard_q};

  assign imem_req_o  = !rst && !redirect_i && (credit_used < DEPTH_V);
  assign imem_addr_o = fetch_pc_q;
  assign grant       = imem_req_o && imem_gnt_i;

  assign drop   = imem_rvalid_i && (discard_q != '0);
  assign accept = imem_rvalid_i && (discard_q == '0);

  assign queue_nonempty = (count_q != '0);

`ifdef FETCH_BYPASS_EN
  assign bypass_hit = accept && !queue_nonempty && !redirect_i;
`else
  assign bypass_hit = 1'b0;
`endif

  assign id_valid_o = !redirect_i && (queue_nonempty || bypass_hit);
  assign empty_o    = !queue_nonempty;

  // The queue storage is not reset, so the outputs read as zero whenever
  // nothing valid is at the head.
  always_comb begin
    id_instr_o = '0;
    id_pc_o    = '0;
    if (bypass_hit) begin
      id_instr_o = imem_rdata_i;
      id_pc_o    = resp_pc_q;
    end else if (queue_nonempty) begin
      id_instr_o = instr_mem[rd_ptr_q];
      id_pc_o    = pc_mem[rd_ptr_q];
    end
  end

  assign pop  = id_valid_o && id_ready_i && queue_nonempty;
  // A bypassed word that decode takes immediately never enters the queue.
  assign push = accept && !redirect_i && !(bypass_hit && id_ready_i);

  // NOTE: every variable gets a default at the top of the block so no path
  // leaves one unassigned; otherwise synthesis infers a latch.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    outst_d    = outst_q;
    discard_d  = discard_q;

    if (redirect_i) begin
      // No request issues this cycle, so the only change to the in-flight
      // count is a response arriving now, which is dropped along with the
      // rest of the old stream.
      fetch_pc_d = redirect_pc_i;
      resp_pc_d  = redirect_pc_i;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      outst_d    = outst_q - OUT_W'(imem_rvalid_i);
      discard_d  = outst_q - OUT_W'(imem_rvalid_i);
    end else begin
      if (grant) begin
        fetch_pc_d = fetch_pc_q + XLEN'(4);
      end
      outst_d = outst_q + OUT_W'(grant) - OUT_W'(imem_rvalid_i);
      if (drop) begin
        discard_d = discard_q - OUT_W'(1);
      end
      if (accept) begin
        resp_pc_d = resp_pc_q + XLEN'(4);
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      outst_q    <= '0;
      discard_q  <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      outst_q    <= outst_d;
      discard_q  <= discard_d;
    end
  end

  // NOTE: the storage array has no reset; count_q alone decides which
  // entries are meaningful, which keeps the array mappable to plain RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]    <= resp_pc_q;
      instr_mem[wr_ptr_q] <= imem_rdata_i;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: an in-order memory model with
// per-request latency, directed scenarios with hand-computed PCs, and a
// randomised run checked against a PC/instruction scoreboard.

module tb_fetch_queue;

  localparam int          XLEN     = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk;
  logic        rst;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        id_valid_o;
  logic        id_ready_i;
  logic [31:0] id_instr_o;
  logic [31:0] id_pc_o;
  logic        empty_o;

  fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .id_valid_o    (id_valid_o),
    .id_ready_i    (id_ready_i),
    .id_instr_o    (id_instr_o),
    .id_pc_o       (id_pc_o),
    .empty_o       (empty_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Memory contents: each word is derived from its own address.
  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return ~a;
  endfunction

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  pend_t       pend[$];
  int          cyc      = 0;
  int          last_due = 0;
  int          lat      = 1;
  bit          gnt_rand = 0;
  bit          sb_en    = 0;
  logic [31:0] exp_pc   = RESET_PC;
  int          pops     = 0;

  // One clock cycle: record the handshakes of the current cycle, cross the
  // rising edge, then present the memory model's inputs for the next cycle.
  task automatic step();
    bit          fire;
    bit          was_rst;
    logic [31:0] a;
    int          due;
    #1;
    fire    = imem_req_o && imem_gnt_i;
    a       = imem_addr_o;
    was_rst = rst;
    if (sb_en) begin
      if (id_valid_o && id_ready_i) begin
        check("sb_pc", id_pc_o, exp_pc);
        check("sb_instr", id_instr_o, instr_of(exp_pc));
        exp_pc = exp_pc + 32'd4;
        pops++;
      end
      if (redirect_i) exp_pc = redirect_pc_i;
    end
    @(posedge clk);
    #1;
    if (was_rst) begin
      pend.delete();
      last_due = 0;
    end else if (fire) begin
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      pend.push_back('{addr: a, due: due});
      last_due = due;
    end
    cyc++;
    if (pend.size() != 0 && pend[0].due <= cyc) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = instr_of(pend[0].addr);
      void'(pend.pop_front());
    end else begin
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = 32'h0;
    end
    imem_gnt_i = gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    #1;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    redirect_i = 1'b0;
    step();
    step();
    rst = 1'b0;
    #1;
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!id_valid_o && n < 40) begin
      step();
      n++;
    end
    check({tag, "_timeout"}, 64'(n < 40), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst           = 1'b1;
    imem_gnt_i    = 1'b1;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = 32'h0;
    redirect_i    = 1'b0;
    redirect_pc_i = 32'h0;
    id_ready_i    = 1'b1;
    step();
    step();

    // Reset state
    check("rst_req",   imem_req_o,  0);
    check("rst_valid", id_valid_o,  0);
    check("rst_empty", empty_o,     1);
    check("rst_addr",  imem_addr_o, RESET_PC);
    check("rst_instr", id_instr_o,  0);
    check("rst_pc",    id_pc_o,     0);

    // Streaming: grant every cycle, 1-cycle latency, decode always ready
    rst = 1'b0;
    #1;
    check("t1_req",  imem_req_o,  1);
    check("t1_addr", imem_addr_o, 32'h0);
    step();
`ifdef FETCH_BYPASS_EN
    check("t1_bypass_valid", id_valid_o, 1);
`else
    check("t1_lat_valid", id_valid_o, 0);
    step();
`endif
    for (int k = 0; k < 8; k++) begin
      check("t1_valid", id_valid_o, 1);
      check("t1_pc",    id_pc_o,    32'(4 * k));
      check("t1_instr", id_instr_o, instr_of(32'(4 * k)));
      step();
    end

    // Stall for 10 cycles: queue fills, requests stop, head stays at pc 0
    do_reset();
    id_ready_i = 1'b0;
    repeat (10) step();
    check("t2_full_req",   imem_req_o, 0);
    check("t2_full_valid", id_valid_o, 1);
    check("t2_full_pc",    id_pc_o,    32'h0);
    check("t2_full_instr", id_instr_o, instr_of(32'h0));
    check("t2_full_empty", empty_o,    0);
    id_ready_i = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) begin
      check("t2_drain_valid", id_valid_o, 1);
      check("t2_drain_pc",    id_pc_o,    32'(4 * k));
      if (k == 0) check("t2_req_still_full", imem_req_o, 0);
      if (k == 1) begin
        check("t2_resume_req",  imem_req_o,  1);
        check("t2_resume_addr", imem_addr_o, 32'h10);
      end
      step();
    end

    // Redirect with 3 outstanding requests
    lat = 4;
    do_reset();
    id_ready_i = 1'b1;
    step();
    step();
    step();
    check("t3_pre_req", imem_req_o, 1);
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h100;
    #1;
    check("t3_rd_valid", id_valid_o, 0);
    check("t3_rd_req",   imem_req_o, 0);
    step();
    redirect_i = 1'b0;
    #1;
    check("t3_req",  imem_req_o,  1);
    check("t3_addr", imem_addr_o, 32'h100);
    wait_valid("t3_wait");
    check("t3_pc",    id_pc_o,    32'h100);
    check("t3_instr", id_instr_o, instr_of(32'h100));
    step();
    check("t3_next_valid", id_valid_o, 1);
    check("t3_next_pc",    id_pc_o,    32'h104);

    // Redirect coinciding with a response and a pending pop
    lat = 2;
    do_reset();
    id_ready_i = 1'b1;
    n = 0;
    while (!(id_valid_o && imem_rvalid_i) && n < 40) begin
      step();
      n++;
    end
    check("t4_sync_timeout", 64'(n < 40), 64'd1);
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h200;
    #1;
    check("t4_rd_valid", id_valid_o, 0);
    check("t4_rd_req",   imem_req_o, 0);
    step();
    redirect_i = 1'b0;
    #1;
    check("t4_empty", empty_o, 1);
    check("t4_addr",  imem_addr_o, 32'h200);
    wait_valid("t4_wait");
    check("t4_pc",    id_pc_o,    32'h200);
    check("t4_instr", id_instr_o, instr_of(32'h200));

    // Random grants, latencies, stalls and redirects against the scoreboard
    lat = 1;
    do_reset();
    exp_pc   = RESET_PC;
    pops     = 0;
    sb_en    = 1;
    gnt_rand = 1;
    for (int i = 0; i < 3000; i++) begin
      lat        = $urandom_range(1, 5);
      id_ready_i = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 49) == 0) begin
        redirect_i    = 1'b1;
        redirect_pc_i = $urandom & 32'h0000_FFFC;
      end else begin
        redirect_i = 1'b0;
      end
      step();
    end
    redirect_i = 1'b0;
    sb_en      = 0;
    gnt_rand   = 0;
    check("t5_enough_pops", 64'(pops > 300), 64'd1);

    // Reset in mid-operation: two buffered entries, two outstanding
    lat = 3;
    do_reset();
    id_ready_i = 1'b0;
    repeat (5) step();
    check("t6_pre_valid", id_valid_o, 1);
    rst = 1'b1;
    step();
    check("t6_valid", id_valid_o,  0);
    check("t6_empty", empty_o,     1);
    check("t6_addr",  imem_addr_o, RESET_PC);
    check("t6_req",   imem_req_o,  0);
    rst        = 1'b0;
    id_ready_i = 1'b1;
    #1;
    check("t6_restart_req", imem_req_o, 1);
    wait_valid("t6_wait");
    check("t6_pc",    id_pc_o,    RESET_PC);
    check("t6_instr", id_instr_o, instr_of(RESET_PC));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
